uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- Serial receive stage directly downstream of the UART baud generator.
- Consumes the generator's 16x `baud_clock` pulse to oversample the asynchronous `rx` line, de-serialises start/data/parity/stop, and checks parity and framing.
- Holds the received byte in a one-deep holding register with valid, overflow and error flags for the APB/FIFO control logic.
- All logic runs on the system clock; `baud_clock` is a one-cycle enable, never a clock.

Parameters:
- SYNC_STAGES, 2, number of flops in the rx metastability synchroniser (legal 2..3).
- SAMPLE_MID, 8, oversample count at the centre of a bit; votes are taken at SAMPLE_MID-1, SAMPLE_MID, SAMPLE_MID+1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `baud_clock`  in  1  16x baud enable pulse, one clk wide.
- `rx`  in  1  asynchronous serial input, idle high.
- `bit8`  in  1  1 = 8 data bits; 0 = 7 data bits.
- `parity_en`  in  1  1 = parity bit expected after the data bits.
- `odd_n_even`  in  1  1 = odd parity; 0 = even parity.
- `read_rx_byte`  in  1  one-cycle pulse: consumer takes `rx_data`.
- `rx_data`  out  8  received byte, LSB first on the line; bit7 = 0 in 7-bit mode.
- `rx_valid`  out  1  holding register full.
- `parity_err`  out  1  parity mismatch on the held byte.
- `framing_err`  out  1  stop bit sampled low on the held byte.
- `overflow`  out  1  sticky: a byte completed while `rx_valid` = 1.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; counters = 0; synchroniser flops = 1.
  - Outputs after reset: `rx_data` = 0, `rx_valid` = 0, `parity_err` = 0, `framing_err` = 0, `overflow` = 0.
  - Reset asserted mid-frame discards the partial frame. Reception restarts on the next falling edge after reset is released.
- `rx` passes through SYNC_STAGES flops, giving `rx_s`. All decisions use `rx_s`.
- Tick counter `tcnt` (4 bits) advances only when `baud_clock` = 1 and wraps 15 -> 0.
- Majority vote:
  - `rx_s` is captured at `tcnt` = 7 and `tcnt` = 8.
  - At `tcnt` = 9, bit = majority of (sample 7, sample 8, current `rx_s`).
- State machine (all transitions qualified by `baud_clock`):
  - IDLE: if `rx_s` = 0 -> START with `tcnt` = 1 (the detecting tick counts as tick 0).
  - START: at `tcnt` = 9, a vote of 1 is a false start -> IDLE; a vote of 0 is kept. At `tcnt` 15 -> 0, go to DATA with bit index 0.
  - DATA: at `tcnt` = 9, shift the vote into the shift register (LSB first). At wrap, the bit index increments. After the last bit (index 7, or 6 when `bit8` = 0), go to PARITY if `parity_en` = 1, else STOP.
  - PARITY: at `tcnt` = 9, latch the vote. Expected value = XOR of the data bits, XOR `odd_n_even`. At wrap -> STOP.
  - STOP: at `tcnt` = 9, complete the frame and go to IDLE immediately (half-bit early, for resync). No wait for wrap, so back-to-back frames are accepted.
- Frame completion (registered, visible 1 clk after the completing `baud_clock` cycle):
  - If `rx_valid` = 0, or `read_rx_byte` = 1 in the same cycle:
    - load `rx_data`;
    - set `parity_err` = mismatch AND `parity_en`;
    - set `framing_err` = NOT stop vote;
    - set `rx_valid` = 1;
    - `overflow` unchanged.
  - Otherwise: keep the old data and flags, and set `overflow` = 1.
- `read_rx_byte` without a simultaneous completion: `rx_valid`, `parity_err`, `framing_err` and `overflow` clear next cycle; `rx_data` holds. Reading while `rx_valid` = 0 has no effect.
- `bit8`, `parity_en` and `odd_n_even` are sampled live. Software changes them only while idle; a mid-frame change gives an undefined frame but no lockup.
- A line stuck low gives repeated frames with `framing_err` = 1. The FSM never hangs.

Decomposition:
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants OVERSAMPLE = 16 and SAMPLE_MID = 8;
  - data width constants 7 and 8.
- Sub-module `uart_rx_bit_sampler`: synchroniser plus 3-sample majority vote, producing `rx_s` and a vote-valid strobe at `tcnt` = 9. The FSM, holding register and flags stay in the top module.

Test Plan:
- 8N1 0xA5 with `baud_clock` every 4 clk -> `rx_valid` = 1 about 154 ticks after the start edge; `rx_data` = 0xA5; all error flags 0.
- 7-bit, even parity, 0x53 with correct parity bit 0 -> `rx_data` = 0x53, `parity_err` = 0. Repeat with parity bit 1 -> `parity_err` = 1.
- Glitch: `rx` low for 3 ticks only -> FSM returns to IDLE at `tcnt` 9; `rx_valid` stays 0.
- Single-tick glitch high at tick 8 of data bit 2 of 0x00 -> vote holds 0; `rx_data` = 0x00.
- Two frames (0x11 then 0x22) with no read -> `rx_data` = 0x11, `overflow` = 1. Then `read_rx_byte` -> all flags clear.
- Stop bit forced low on 0x3C -> `framing_err` = 1, `rx_data` = 0x3C.
- Reset pulsed during DATA bit 4 -> outputs at reset values. The next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  // Receive FSM states; encoding is also what the debug output reports.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_MID  = 8;
  localparam int DATA_BITS_7 = 7;
  localparam int DATA_BITS_8 = 8;

  // 2-of-3 majority used for the mid-bit vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// rx synchroniser and 3-sample majority vote around the bit centre.
// The vote is presented combinationally together with vote_stb, which
// marks the baud tick one past the centre (third sample point).
module uart_rx_bit_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_MID  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic [3:0] tcnt,
  output logic       rx_s,
  output logic       vote_stb,
  output logic       vote
);
  import uart_pkg::*;

  localparam logic [3:0] T_EARLY = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] T_MID   = 4'(SAMPLE_MID);
  localparam logic [3:0] T_LATE  = 4'(SAMPLE_MID + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_early;
  logic                   s_mid;

  // Metastability chain; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Capture the two samples that precede the deciding tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (baud_clock) begin
      if (tcnt == T_EARLY) s_early <= rx_s;
      if (tcnt == T_MID)   s_mid   <= rx_s;
    end
  end

  assign vote_stb = baud_clock && (tcnt == T_LATE);
  assign vote     = majority3(s_early, s_mid, rx_s);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive stage: oversampled start/data/parity/stop de-serialiser
// with a one-deep holding register and error/overflow flags.
//
// Holding register handshake: rx_valid = 1 means rx_data, parity_err and
// framing_err describe an unread byte. A one-cycle read_rx_byte while
// rx_valid = 1 consumes it (flags clear next cycle, rx_data holds). A frame
// completing while rx_valid = 1 and no read is dropped and sets the sticky
// overflow flag; a frame completing in the same cycle as a read is loaded.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_MID  = uart_pkg::SAMPLE_MID
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic [2:0] state_dbg
);
  import uart_pkg::*;

  rx_state_e  state;
  logic [3:0] tcnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       par_bit;

  logic       rx_s;
  logic       vote_stb;
  logic       vote;

  logic       last_bit;
  logic       tcnt_wrap;
  logic       frame_done;
  logic [7:0] frame_data;
  logic       parity_bad;

  uart_rx_bit_sampler #(
    .SYNC_STAGES (SYNC_STAGES),
    .SAMPLE_MID  (SAMPLE_MID)
  ) u_bit_sampler (
    .clk        (clk),
    .reset      (reset),
    .baud_clock (baud_clock),
    .rx         (rx),
    .tcnt       (tcnt),
    .rx_s       (rx_s),
    .vote_stb   (vote_stb),
    .vote       (vote)
  );

  assign last_bit   = (bit_idx == (bit8 ? 3'(DATA_BITS_8 - 1) : 3'(DATA_BITS_7 - 1)));
  assign tcnt_wrap  = (tcnt == 4'(OVERSAMPLE - 1));
  assign frame_done = (state == STOP) && vote_stb;
  assign frame_data = bit8 ? shreg : {1'b0, shreg[6:0]};
  assign parity_bad = ((^frame_data) ^ odd_n_even) != par_bit;
  assign state_dbg  = state;

  // Frame sequencer: bit timing, data shift and parity capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (baud_clock) begin
      case (state)
        IDLE: begin
          // The detecting tick is tick 0 of the start bit.
          if (!rx_s) begin
            state   <= START;
            tcnt    <= 4'd1;
            bit_idx <= '0;
            shreg   <= '0;
          end
        end
        START: begin
          tcnt <= tcnt + 4'd1;
          if (vote_stb && vote) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (tcnt_wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          tcnt <= tcnt + 4'd1;
          if (vote_stb) shreg[bit_idx] <= vote;
          if (tcnt_wrap) begin
            if (last_bit) state <= parity_en ? PARITY : STOP;
            else          bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          tcnt <= tcnt + 4'd1;
          if (vote_stb) par_bit <= vote;
          if (tcnt_wrap) state <= STOP;
        end
        STOP: begin
          // Leave mid stop bit so a following start edge is never missed.
          tcnt <= tcnt + 4'd1;
          if (vote_stb) begin
            state <= IDLE;
            tcnt  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

  // Holding register, error flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else if (frame_done) begin
      if (!rx_valid || read_rx_byte) begin
        rx_data     <= frame_data;
        parity_err  <= parity_bad && parity_en;
        framing_err <= !vote;
        rx_valid    <= 1'b1;
      end else begin
        overflow    <= 1'b1;
      end
    end else if (read_rx_byte && rx_valid) begin
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: frames are generated bit by bit on rx, a
// line-level model predicts each held byte and its flags, and a monitor
// compares whenever rx_valid rises.
module tb_uart_rx_sampler;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx_byte;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected held result: {parity_err, framing_err, rx_data}.
  logic [9:0] exp_q[$];

  // Reference model of the holding register.
  logic       model_valid;
  logic       model_overflow;
  logic [7:0] model_held;

  int unsigned tick_cnt = 0;
  int unsigned start_tick;
  int unsigned rise_tick;
  logic        prev_valid = 1'b0;

  uart_rx_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .baud_clock   (baud_clock),
    .rx           (rx),
    .bit8         (bit8),
    .parity_en    (parity_en),
    .odd_n_even   (odd_n_even),
    .read_rx_byte (read_rx_byte),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .parity_err   (parity_err),
    .framing_err  (framing_err),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  // Clock and 16x baud enable (one pulse every 4 clk).
  always #5 clk = ~clk;

  initial begin
    baud_clock = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_clock = 1'b1;
      @(negedge clk);
      baud_clock = 1'b0;
    end
  end

  always @(posedge clk) if (baud_clock) tick_cnt <= tick_cnt + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: compare on every new held byte.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rx_valid && !prev_valid) begin
      rise_tick = tick_cnt;
      if (exp_q.size() == 0) begin
        check("frame_was_expected", 32'(exp_q.size() > 0), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e[7:0]));
        check("parity_err", 32'(parity_err), 32'(e[9]));
        check("framing_err", 32'(framing_err), 32'(e[8]));
      end
    end
    prev_valid = rx_valid;
  end

  // Wait for n baud ticks (posedges on which baud_clock is high).
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (baud_clock !== 1'b1);
    end
  endtask

  // One bit period; optional one-tick inverted glitch at the centre tick.
  task automatic drive_bit(input logic v, input logic glitch);
    @(negedge clk);
    rx = v;
    if (glitch) begin
      wait_ticks(8);
      @(negedge clk); rx = ~v;
      wait_ticks(1);
      @(negedge clk); rx = v;
      wait_ticks(7);
    end else begin
      wait_ticks(16);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    rx             = 1'b1;
    model_valid    = 1'b0;
    model_overflow = 1'b0;
    model_held     = 8'h00;
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pe,
                            input logic odd, input logic par_flip, input logic stop_bad,
                            input int glitch_bit, input int abort_bit, input int gap);
    logic [7:0] dd;
    logic       par_sent;
    int         nbits;
    @(negedge clk);
    bit8       = b8;
    parity_en  = pe;
    odd_n_even = odd;
    nbits      = b8 ? 8 : 7;
    dd         = b8 ? d : {1'b0, d[6:0]};
    par_sent   = (^dd) ^ odd ^ par_flip;
    if (abort_bit < 0) begin
      if (!model_valid) begin
        model_valid = 1'b1;
        model_held  = dd;
        exp_q.push_back({pe && (par_sent != ((^dd) ^ odd)), stop_bad, dd});
      end else begin
        model_overflow = 1'b1;
      end
    end
    @(negedge clk);
    rx = 1'b0;
    start_tick = tick_cnt;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_bit) begin
        @(negedge clk); rx = d[i];
        wait_ticks(8);
        do_reset();
        return;
      end
      drive_bit(d[i], i == glitch_bit);
    end
    if (pe) drive_bit(par_sent, 1'b0);
    drive_bit(!stop_bad, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(gap);
  endtask

  task automatic read_byte();
    @(negedge clk); read_rx_byte = 1'b1;
    @(negedge clk); read_rx_byte = 1'b0;
    model_valid    = 1'b0;
    model_overflow = 1'b0;
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'(model_valid));
    check({tag, "_overflow"}, 32'(overflow), 32'(model_overflow));
    check({tag, "_held_data"}, 32'(rx_data), 32'(model_held));
  endtask

  task automatic read_and_check(input string tag);
    read_byte();
    check_hold(tag);
    check({tag, "_perr_clr"}, 32'(parity_err), 32'd0);
    check({tag, "_ferr_clr"}, 32'(framing_err), 32'd0);
  endtask

  initial begin
    int unsigned lat;
    logic [7:0] rd;
    logic rb8, rpe, rodd, rflip, rstop;
    int rglitch, rgap;

    reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    read_rx_byte = 1'b0;
    model_valid = 1'b0; model_overflow = 1'b0; model_held = 8'h00;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_framing_err", 32'(framing_err), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    wait_ticks(5);

    // 8N1 0xA5 and its completion latency in baud ticks.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 4);
    lat = rise_tick - start_tick;
    check($sformatf("latency_154_ticks_got_%0d", lat), 32'(lat >= 152 && lat <= 156), 32'd1);
    check_hold("a5");
    read_and_check("a5_read");

    // 7-bit even parity 0x53, correct then wrong parity bit.
    send_frame(8'h53, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 4);
    read_and_check("p53_ok");
    send_frame(8'h53, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 4);
    read_and_check("p53_bad");

    // False start: low for 3 ticks only.
    @(negedge clk); bit8 = 1'b1; parity_en = 1'b0; rx = 1'b0;
    wait_ticks(3);
    @(negedge clk); rx = 1'b1;
    wait_ticks(20);
    check("false_start_state", 32'(state_dbg), 32'(IDLE));
    check("false_start_valid", 32'(rx_valid), 32'd0);

    // Centre glitch on data bit 2 of 0x00 is outvoted.
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1, 4);
    read_and_check("glitch00");

    // Two frames without a read: second is dropped, overflow set.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 2);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 4);
    check_hold("ovf");
    read_and_check("ovf_read");

    // Stop bit low on 0x3C.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 24);
    read_and_check("stop_bad");

    // Hold a byte, then reset during data bit 4 of the next frame.
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 2);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 4, 0);
    @(negedge clk);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_overflow", 32'(overflow), 32'h0);
    check("midreset_state", 32'(state_dbg), 32'(IDLE));
    wait_ticks(30);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 4);
    read_and_check("after_reset");

    // Randomized frames, occasionally skipping a read to provoke overflow.
    for (int n = 0; n < 18; n++) begin
      rd      = 8'($urandom_range(0, 255));
      rb8     = 1'($urandom_range(0, 1));
      rpe     = 1'($urandom_range(0, 1));
      rodd    = 1'($urandom_range(0, 1));
      rflip   = ($urandom_range(0, 3) == 0);
      rstop   = ($urandom_range(0, 5) == 0);
      rglitch = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rb8 ? 7 : 6)) : -1;
      rgap    = (rstop ? 20 : 0) + int'($urandom_range(0, 6));
      send_frame(rd, rb8, rpe, rodd, rflip, rstop, rglitch, -1, rgap);
      check_hold($sformatf("rnd%0d", n));
      if ($urandom_range(0, 4) != 0) read_and_check($sformatf("rnd%0d_read", n));
    end
    read_byte();

    wait_ticks(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
